// File: rtl/bp_load_scheduler.sv
// Tile sequencer for the BP buffer loader: issues one loader configuration per tile,
// ping-ponging between bank halves, and offers loaded tiles to compute via valid/release.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no job; waiting for start
// ISSUE     | job active; conf the next tile when its half is free
// WAIT_BUSY | conf sent; waiting for the loader to leave idle
// WAIT_IDLE | loader running; waiting for it to return to idle
module bp_load_scheduler #(
  parameter int DDR_ADDR_LEN = 32,
  parameter int ADDR_LEN     = 16,
  parameter int SINGLE_LEN   = 24,
  parameter int TILE_LEN     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [DDR_ADDR_LEN-1:0] cfg_ddr_base,
  input  logic [DDR_ADDR_LEN-1:0] cfg_ddr_stride,
  input  logic [SINGLE_LEN-1:0]   cfg_tile_bytes,
  input  logic [TILE_LEN-1:0]     cfg_tile_num,
  input  logic [SINGLE_LEN-1:0]   cfg_line_width,
  input  logic [ADDR_LEN-1:0]     cfg_bp_addr,
  output logic                    busy,
  output logic                    done,
  output logic                    ld_conf,
  output logic [DDR_ADDR_LEN-1:0] ld_ddr_addr,
  output logic [SINGLE_LEN-1:0]   ld_data_ddr_byte,
  output logic [ADDR_LEN-1:0]     ld_bp_st_addr,
  output logic [1:0]              ld_bp_st_num,
  output logic [SINGLE_LEN-1:0]   ld_line_width,
  input  logic                    ld_idle,
  output logic                    tile_valid,
  output logic                    tile_half,
  output logic [TILE_LEN-1:0]     tile_idx,
  input  logic                    tile_release
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_IDLE = 2'd3;

  logic [1:0]              state_q, state_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    ld_conf_q, ld_conf_d;
  logic [DDR_ADDR_LEN-1:0] ld_ddr_addr_q, ld_ddr_addr_d;
  logic [SINGLE_LEN-1:0]   ld_bytes_q, ld_bytes_d;
  logic [ADDR_LEN-1:0]     ld_bp_addr_q, ld_bp_addr_d;
  logic [1:0]              ld_st_num_q, ld_st_num_d;
  logic [SINGLE_LEN-1:0]   ld_lw_q, ld_lw_d;
  logic [DDR_ADDR_LEN-1:0] stride_q, stride_d;
  logic [TILE_LEN-1:0]     tile_num_q, tile_num_d;
  logic [TILE_LEN-1:0]     issued_q, issued_d;
  logic [TILE_LEN-1:0]     released_q, released_d;
  logic [DDR_ADDR_LEN-1:0] next_addr_q, next_addr_d;
  logic                    load_ptr_q, load_ptr_d;
  logic                    cons_ptr_q, cons_ptr_d;
  logic [1:0]              full_q, full_d;
  logic                    rel_fire;

  assign rel_fire = tile_release & full_q[cons_ptr_q];

  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    ld_conf_d     = 1'b0;
    ld_ddr_addr_d = ld_ddr_addr_q;
    ld_bytes_d    = ld_bytes_q;
    ld_bp_addr_d  = ld_bp_addr_q;
    ld_st_num_d   = ld_st_num_q;
    ld_lw_d       = ld_lw_q;
    stride_d      = stride_q;
    tile_num_d    = tile_num_q;
    issued_d      = issued_q;
    released_d    = released_q;
    next_addr_d   = next_addr_q;
    load_ptr_d    = load_ptr_q;
    cons_ptr_d    = cons_ptr_q;
    full_d        = full_q;

    // Consumer side is independent of the FSM; a release and a load completion
    // always target different halves, so both updates apply.
    if (rel_fire) begin
      full_d[cons_ptr_q] = 1'b0;
      cons_ptr_d         = ~cons_ptr_q;
      released_d         = released_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ld_bytes_d   = cfg_tile_bytes;
          ld_bp_addr_d = cfg_bp_addr;
          ld_lw_d      = cfg_line_width;
          stride_d     = cfg_ddr_stride;
          tile_num_d   = cfg_tile_num;
          issued_d     = '0;
          released_d   = '0;
          next_addr_d  = cfg_ddr_base;
          load_ptr_d   = 1'b0;
          cons_ptr_d   = 1'b0;
          full_d       = 2'b00;
          busy_d       = 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (released_d == tile_num_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if ((issued_q < tile_num_q) && !full_q[load_ptr_q]) begin
          ld_conf_d     = 1'b1;
          ld_ddr_addr_d = next_addr_q;
          ld_st_num_d   = {load_ptr_q, 1'b0};
          state_d       = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (!ld_idle) state_d = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (ld_idle) begin
          full_d[load_ptr_q] = 1'b1;
          load_ptr_d         = ~load_ptr_q;
          issued_d           = issued_q + 1'b1;
          next_addr_d        = next_addr_q + stride_q;
          state_d            = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ld_conf_q     <= 1'b0;
      ld_ddr_addr_q <= '0;
      ld_bytes_q    <= '0;
      ld_bp_addr_q  <= '0;
      ld_st_num_q   <= '0;
      ld_lw_q       <= '0;
      stride_q      <= '0;
      tile_num_q    <= '0;
      issued_q      <= '0;
      released_q    <= '0;
      next_addr_q   <= '0;
      load_ptr_q    <= 1'b0;
      cons_ptr_q    <= 1'b0;
      full_q        <= 2'b00;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      ld_conf_q     <= ld_conf_d;
      ld_ddr_addr_q <= ld_ddr_addr_d;
      ld_bytes_q    <= ld_bytes_d;
      ld_bp_addr_q  <= ld_bp_addr_d;
      ld_st_num_q   <= ld_st_num_d;
      ld_lw_q       <= ld_lw_d;
      stride_q      <= stride_d;
      tile_num_q    <= tile_num_d;
      issued_q      <= issued_d;
      released_q    <= released_d;
      next_addr_q   <= next_addr_d;
      load_ptr_q    <= load_ptr_d;
      cons_ptr_q    <= cons_ptr_d;
      full_q        <= full_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign ld_conf          = ld_conf_q;
  assign ld_ddr_addr      = ld_ddr_addr_q;
  assign ld_data_ddr_byte = ld_bytes_q;
  assign ld_bp_st_addr    = ld_bp_addr_q;
  assign ld_bp_st_num     = ld_st_num_q;
  assign ld_line_width    = ld_lw_q;
  assign tile_valid       = full_q[cons_ptr_q];
  assign tile_half        = cons_ptr_q;
  assign tile_idx         = released_q;

endmodule

// File: tb/tb_bp_load_scheduler.sv
// Scoreboard bench for bp_load_scheduler: stimulus pushes expected confs/tiles,
// a negedge monitor with a loader and compute model pops and compares.
module tb_bp_load_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] cfg_ddr_base, cfg_ddr_stride;
  logic [23:0] cfg_tile_bytes, cfg_line_width;
  logic [15:0] cfg_tile_num, cfg_bp_addr;
  logic        busy, done, ld_conf;
  logic [31:0] ld_ddr_addr;
  logic [23:0] ld_data_ddr_byte, ld_line_width;
  logic [15:0] ld_bp_st_addr;
  logic [1:0]  ld_bp_st_num;
  logic        ld_idle = 1'b1;
  logic        tile_valid, tile_half;
  logic [15:0] tile_idx;
  logic        tile_release = 1'b0;

  bp_load_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_ddr_base(cfg_ddr_base), .cfg_ddr_stride(cfg_ddr_stride),
    .cfg_tile_bytes(cfg_tile_bytes), .cfg_tile_num(cfg_tile_num),
    .cfg_line_width(cfg_line_width), .cfg_bp_addr(cfg_bp_addr),
    .busy(busy), .done(done), .ld_conf(ld_conf), .ld_ddr_addr(ld_ddr_addr),
    .ld_data_ddr_byte(ld_data_ddr_byte), .ld_bp_st_addr(ld_bp_st_addr),
    .ld_bp_st_num(ld_bp_st_num), .ld_line_width(ld_line_width), .ld_idle(ld_idle),
    .tile_valid(tile_valid), .tile_half(tile_half), .tile_idx(tile_idx),
    .tile_release(tile_release)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  logic [31:0] q_addr[$];
  logic [1:0]  q_st[$];
  logic        q_half[$];
  logic [15:0] q_idx[$];
  logic [23:0] e_bytes, e_lw;
  logic [15:0] e_bp, e_num;
  int conf_cyc[$], rel_cyc[$];
  int start_cyc = 0, conf_cnt = 0, rel_cnt = 0, done_cnt = 0, last_rel_cyc = 0;
  int ld_st = 0, ld_cnt = 0, lat_min = 1, lat_max = 1;
  int rel_wait = 0, rel_min = 0, rel_max = 0;
  bit rel_hold = 1'b0, sim_mode = 1'b0, sim_chk = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic do_release();
    tile_release = 1'b1;
    rel_cnt++;
    rel_cyc.push_back(cyc);
    last_rel_cyc = cyc;
    if (q_half.size() == 0) fail_now("release_unexpected");
    else begin
      chk("tile_half", tile_half, q_half.pop_front());
      chk("tile_idx", tile_idx, q_idx.pop_front());
    end
  endtask

  // Monitor + loader model + compute model, all sampled on the falling edge.
  always @(negedge clk) begin
    bit ld_rise;
    int k;
    ld_rise = 1'b0;
    cyc++;
    if (!rst_n) begin
      ld_idle = 1'b1;
      ld_st = 0;
      tile_release = 1'b0;
      sim_chk = 1'b0;
    end else begin
      if (ld_conf) begin
        k = conf_cnt;
        chk("conf_loader_idle", ld_idle, 1);
        if (q_addr.size() == 0) fail_now("conf_unexpected");
        else begin
          chk("conf_addr", ld_ddr_addr, q_addr.pop_front());
          chk("conf_st_num", ld_bp_st_num, q_st.pop_front());
          chk("conf_bytes", ld_data_ddr_byte, e_bytes);
          chk("conf_bp_addr", ld_bp_st_addr, e_bp);
          chk("conf_line_width", ld_line_width, e_lw);
        end
        if (k == 0) chk("conf_first_latency", cyc, start_cyc + 2);
        if (k >= 2) chk("conf_residency", rel_cnt >= k - 1, 1);
        conf_cyc.push_back(cyc);
        conf_cnt++;
        ld_st = 1;
      end else if (ld_st == 1) begin
        ld_idle = 1'b0;
        ld_cnt = $urandom_range(lat_max, lat_min);
        ld_st = 2;
      end else if (ld_st == 2) begin
        ld_cnt--;
        if (ld_cnt <= 0) begin
          ld_idle = 1'b1;
          ld_st = 0;
          ld_rise = 1'b1;
        end
      end

      if (done) begin
        chk("done_busy_low", busy, 0);
        chk("done_rel_count", rel_cnt, e_num);
        chk("done_conf_count", conf_cnt, e_num);
        if (e_num == 0) chk("done_latency_zero", cyc, start_cyc + 2);
        else chk("done_after_release", cyc, last_rel_cyc + 1);
        done_cnt++;
      end

      if (sim_chk) begin
        chk("sim_valid", tile_valid, 1);
        chk("sim_half", tile_half, 1);
        chk("sim_idx", tile_idx, 1);
        sim_chk = 1'b0;
      end

      if (tile_release) tile_release = 1'b0;
      else if (tile_valid && !rel_hold) begin
        if (rel_wait <= 0) begin
          do_release();
          rel_wait = $urandom_range(rel_max, rel_min);
        end else rel_wait--;
      end

      // Release half 0 on the same edge the loader finishes half 1.
      if (ld_rise && sim_mode && tile_valid && !tile_release) begin
        do_release();
        sim_mode = 1'b0;
        sim_chk = 1'b1;
      end
    end
  end

  task automatic run_job(input logic [31:0] base, input logic [31:0] stride,
                         input logic [23:0] bytes, input logic [23:0] lw,
                         input logic [15:0] num, input logic [15:0] bp,
                         input int lmin, input int lmax, input int rmin, input int rmax,
                         input bit hold);
    logic [31:0] a;
    @(posedge clk); #1;
    cfg_ddr_base = base; cfg_ddr_stride = stride; cfg_tile_bytes = bytes;
    cfg_line_width = lw; cfg_tile_num = num; cfg_bp_addr = bp;
    e_bytes = bytes; e_lw = lw; e_num = num; e_bp = bp;
    q_addr.delete(); q_st.delete(); q_half.delete(); q_idx.delete();
    conf_cyc.delete(); rel_cyc.delete();
    a = base;
    for (int k = 0; k < int'(num); k++) begin
      q_addr.push_back(a);
      q_st.push_back(2'((k % 2) * 2));
      q_half.push_back(1'(k % 2));
      q_idx.push_back(16'(k));
      a = a + stride;
    end
    conf_cnt = 0; rel_cnt = 0;
    lat_min = lmin; lat_max = lmax; rel_min = rmin; rel_max = rmax;
    rel_wait = $urandom_range(rmax, rmin);
    rel_hold = hold;
    start = 1'b1;
    @(posedge clk);
    start_cyc = cyc;
    #1 start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int budget);
    int d0, n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == d0) fail_now("done_timeout");
    chk("queues_drained", q_addr.size() + q_half.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ld_conf"}, ld_conf, 0);
    chk({tag, "_ld_addr"}, ld_ddr_addr, 0);
    chk({tag, "_ld_bytes"}, ld_data_ddr_byte, 0);
    chk({tag, "_ld_st_num"}, ld_bp_st_num, 0);
    chk({tag, "_tile_valid"}, tile_valid, 0);
    chk({tag, "_tile_half"}, tile_half, 0);
    chk({tag, "_tile_idx"}, tile_idx, 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0;
    cfg_ddr_base = '0; cfg_ddr_stride = '0; cfg_tile_bytes = '0;
    cfg_line_width = '0; cfg_tile_num = '0; cfg_bp_addr = '0;
    e_bytes = '0; e_lw = '0; e_bp = '0; e_num = '0;
    repeat (3) @(posedge clk);
    #1 check_idle_outputs("reset");
    rst_n = 1'b1;

    // Single tile
    run_job(32'h1000, 32'h800, 24'h400, 24'h40, 16'd1, 16'h10, 20, 20, 5, 5, 1'b0);
    wait_done(500);

    // Ping-pong with releases held off
    run_job(32'h1000, 32'h800, 24'h400, 24'h40, 16'd4, 16'h20, 3, 6, 0, 0, 1'b1);
    repeat (60) @(posedge clk);
    #1;
    chk("pp_conf_held", conf_cnt, 2);
    chk("pp_valid_held", tile_valid, 1);
    rel_hold = 1'b0;
    n = 0;
    while (conf_cnt < 3 && n < 100) begin @(posedge clk); n++; end
    if (conf_cyc.size() >= 3 && rel_cyc.size() >= 1)
      chk("pp_third_conf_latency", conf_cyc[2] - rel_cyc[0], 2);
    else fail_now("pp_third_conf_missing");
    wait_done(1000);

    // Load completion of half 1 coinciding with release of half 0
    run_job(32'h4000, 32'h100, 24'h80, 24'h8, 16'd2, 16'h0, 8, 8, 0, 0, 1'b1);
    sim_mode = 1'b1;
    n = 0;
    while (sim_mode && n < 200) begin @(posedge clk); n++; end
    if (sim_mode) begin fail_now("sim_not_reached"); sim_mode = 1'b0; end
    #1 rel_hold = 1'b0;
    wait_done(500);

    // Zero tiles
    run_job(32'h5000, 32'h100, 24'h10, 24'h4, 16'd0, 16'h7, 1, 1, 0, 0, 1'b0);
    wait_done(20);

    // Address wrap
    run_job(32'hFFFF_F000, 32'h800, 24'h100, 24'h10, 16'd3, 16'h40, 1, 5, 0, 4, 1'b0);
    wait_done(1000);

    // Ignored start mid-job, then asynchronous reset mid-load
    run_job(32'h8000, 32'h1000, 24'h200, 24'h10, 16'd3, 16'h30, 4, 8, 1, 3, 1'b0);
    n = 0;
    while (!(conf_cnt >= 1 && !ld_idle) && n < 200) begin @(posedge clk); n++; end
    @(posedge clk); #1;
    cfg_ddr_base = 32'hDEAD_0000; cfg_ddr_stride = 32'h4; cfg_tile_bytes = 24'h7;
    cfg_line_width = 24'h3; cfg_tile_num = 16'd9; cfg_bp_addr = 16'h55;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (!(conf_cnt >= 2 && !ld_idle) && n < 400) begin @(posedge clk); n++; end
    if (conf_cnt < 2) fail_now("reset_setup_timeout");
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1 check_idle_outputs("async_reset");
    q_addr.delete(); q_st.delete(); q_half.delete(); q_idx.delete();
    rel_hold = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    run_job(32'h9000, 32'h200, 24'h300, 24'h20, 16'd3, 16'h11, 1, 6, 0, 3, 1'b0);
    wait_done(1000);

    // Randomized jobs
    for (int j = 0; j < 6; j++) begin
      run_job($urandom, $urandom, 24'($urandom), 24'($urandom), 16'($urandom_range(6, 1)),
              16'($urandom), 1, $urandom_range(10, 1), 0, $urandom_range(6, 0), 1'b0);
      wait_done(3000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
